// File: rtl/instruction_align_buffer.sv
// Fetch-side halfword FIFO that realigns 32-bit memory words into RV32I/RV32C instructions.
// Optional macro RV32C_ALIGN_EN enables 16-bit instructions and halfword-aligned redirects.
module instruction_align_buffer #(
    parameter int unsigned DEPTH    = 8,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        iCLK,
    input  logic        iRST,
    output logic        oFETCH_REQ,
    output logic [31:0] oFETCH_ADDR,
    input  logic        iFETCH_ACK,
    input  logic [31:0] iFETCH_DATA,
    input  logic        iREDIRECT,
    input  logic [31:0] iREDIRECT_PC,
    output logic        oVALID,
    input  logic        iREADY,
    output logic [31:0] oIR,
    output logic [15:0] oIR_C,
    output logic [31:0] oPC,
    output logic        oMISALIGN
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [15:0]   mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   pc_q, pc_d, addr_q, addr_d;
    logic          req_q, req_d, skip_q, skip_d, drop_q, drop_d, mis_q, mis_d;
    logic [15:0]   hw0, hw1;
    logic          is32, take, fire;
    logic [1:0]    push_n, pop_n;
    logic [31:0]   redir_pc;

    assign hw0      = mem_q[rd_ptr_q];
    assign hw1      = mem_q[rd_ptr_q + AW'(1)];
    assign redir_pc = iREDIRECT_PC & ~32'h1;

`ifdef RV32C_ALIGN_EN
    assign is32   = (hw0[1:0] == 2'b11);
    assign oVALID = is32 ? (count_q >= CW'(2)) : (count_q >= CW'(1));
    assign oIR    = is32 ? {hw1, hw0} : {16'h0000, hw0};
    assign oIR_C  = hw0;
`else
    assign is32   = 1'b1;
    assign oVALID = (count_q >= CW'(2)) && !mis_q;
    assign oIR    = {hw1, hw0};
    assign oIR_C  = 16'h0003;
`endif

    // Handshake: an instruction transfers on a cycle where oVALID & iREADY; the head
    // outputs come straight from registers, so they hold while oVALID & ~iREADY.
    // A fetch response is consumed only for the request we still care about.
    assign take   = iFETCH_ACK && req_q && !drop_q && !iREDIRECT;
    assign fire   = oVALID && iREADY;
    assign push_n = take ? (skip_q ? 2'd1 : 2'd2) : 2'd0;
    assign pop_n  = fire ? (is32 ? 2'd2 : 2'd1) : 2'd0;

    always_comb begin
        count_d  = count_q + CW'(push_n) - CW'(pop_n);
        rd_ptr_d = rd_ptr_q + AW'(pop_n);
        wr_ptr_d = wr_ptr_q + AW'(push_n);
        pc_d     = pc_q + {29'd0, pop_n, 1'b0};
        addr_d   = take ? addr_q + 32'd4 : addr_q;
        skip_d   = take ? 1'b0 : skip_q;
        drop_d   = 1'b0;
        req_d    = req_q ? !iFETCH_ACK : (count_q <= CW'(DEPTH - 2));
        mis_d    = mis_q;
        if (iREDIRECT) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            pc_d     = redir_pc;
            addr_d   = {redir_pc[31:2], 2'b00};
            skip_d   = redir_pc[1];
            drop_d   = req_q && !iFETCH_ACK;
            req_d    = 1'b0;
`ifdef RV32C_ALIGN_EN
            mis_d    = 1'b0;
`else
            mis_d    = redir_pc[1];
`endif
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            pc_q     <= RESET_PC;
            addr_q   <= {RESET_PC[31:2], 2'b00};
            req_q    <= 1'b0;
            skip_q   <= RESET_PC[1];
            drop_q   <= 1'b0;
            mis_q    <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            pc_q     <= pc_d;
            addr_q   <= addr_d;
            req_q    <= req_d;
            skip_q   <= skip_d;
            drop_q   <= drop_d;
            mis_q    <= mis_d;
        end
    end

    // Storage needs no reset: count gates every read.
    always_ff @(posedge iCLK) begin
        if (take) begin
            if (skip_q) begin
                mem_q[wr_ptr_q] <= iFETCH_DATA[31:16];
            end else begin
                mem_q[wr_ptr_q]          <= iFETCH_DATA[15:0];
                mem_q[wr_ptr_q + AW'(1)] <= iFETCH_DATA[31:16];
            end
        end
    end

    assign oFETCH_REQ  = req_q;
    assign oFETCH_ADDR = addr_q;
    assign oPC         = pc_q;
    assign oMISALIGN   = mis_q;

endmodule
